// File: rtl/btn_event_pkg.sv
// Shared constants for btn_event: 3-bit FSM state encoding, default tick counts
// and the registered event bundle.
package btn_event_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRESS1 = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] PRESS2 = 3'd3;
    localparam logic [2:0] HELD   = 3'd4;

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_LONG_TICKS   = 100;
    localparam int DEF_DCLICK_TICKS = 25;
    localparam int DEF_REPEAT_TICKS = 20;

    typedef struct packed {
        logic short_press;
        logic long_press;
        logic double_click;
    } ev_t;

endpackage

// File: rtl/btn_event_if.sv
// Button-in / event-pulses-out bundle for btn_event. The master drives tick and btn;
// the slave (btn_event) returns the event pulses and busy.
interface btn_event_if;

    logic tick;
    logic btn;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_press;
    logic busy;

    modport master (
        output tick, btn,
        input  short_press, long_press, double_click, repeat_press, busy
    );

    modport slave (
        input  tick, btn,
        output short_press, long_press, double_click, repeat_press, busy
    );

endinterface

// File: rtl/btn_edge_det.sv
// Rise/fall detector on the debounced button level. The history register resets to 1,
// so a button held through reset has to be released before a press is seen.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise,
    output logic fall
);

    logic btn_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b1;
        else     btn_q <= btn;
    end

    assign rise = btn  & ~btn_q;
    assign fall = ~btn &  btn_q;

endmodule

// File: rtl/btn_event.sv
// Button event classifier: short press, long press, double click and auto-repeat.
// The auto-repeat path exists only when BTN_EVENT_REPEAT_EN is defined.
module btn_event
    import btn_event_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic        clk,
    input  logic        rst,
    btn_event_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

    logic             rise;
    logic             fall;
    logic             tick_eff;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap;
    ev_t              ev_nxt;
    ev_t              ev_q;
    logic             busy_q;

    btn_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn),
        .rise (rise),
        .fall (fall)
    );

    // An edge in the same clock as a tick takes priority; that tick is dropped.
    assign tick_eff = bus.tick & ~rise & ~fall;

`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    logic repeat_q;

    always_ff @(posedge clk) begin
        if (rst) repeat_q <= 1'b0;
        else     repeat_q <= (state == HELD) && !fall && tick_eff && (cnt == REPEAT_LAST);
    end

    assign cnt_wrap         = (state == HELD) && !fall && tick_eff && (cnt == REPEAT_LAST);
    assign bus.repeat_press = repeat_q;
`else
    assign cnt_wrap         = 1'b0;
    assign bus.repeat_press = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_nxt = state;
        ev_nxt    = '0;
        case (state)
            IDLE: begin
                if (rise) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_nxt = GAP;
                end else if (tick_eff && cnt == LONG_LAST) begin
                    state_nxt         = HELD;
                    ev_nxt.long_press = 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    state_nxt           = PRESS2;
                    ev_nxt.double_click = 1'b1;
                end else if (tick_eff && cnt == DCLICK_LAST) begin
                    state_nxt          = IDLE;
                    ev_nxt.short_press = 1'b1;
                end
            end
            PRESS2, HELD: begin
                if (fall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: synchronous reset clears state, counter and pulses, discarding any pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ev_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ev_q   <= ev_nxt;
            busy_q <= (state_nxt != IDLE);
            if (state_nxt != state || cnt_wrap) cnt <= '0;
            else if (tick_eff && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    assign bus.short_press  = ev_q.short_press;
    assign bus.long_press   = ev_q.long_press;
    assign bus.double_click = ev_q.double_click;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with CNT_W=4, LONG=4, DCLICK=3, REPEAT=2 and a tick
// every second clock; expectations are hand-derived tick counts.
module tb_btn_event;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_short, n_long, n_dbl, n_rep, n_multi;
    logic rep_en;

    always #5 clk = ~clk;

    btn_event_if bus ();

    btn_event #(
        .CNT_W        (4),
        .LONG_TICKS   (4),
        .DCLICK_TICKS (3),
        .REPEAT_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0; n_multi = 0;
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic b, input logic t);
        int s;
        bus.btn  = b;
        bus.tick = t;
        @(posedge clk);
        #1;
        s = int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_click) + int'(bus.repeat_press);
        n_short += int'(bus.short_press);
        n_long  += int'(bus.long_press);
        n_dbl   += int'(bus.double_click);
        n_rep   += int'(bus.repeat_press);
        if (s > 1) n_multi++;
    endtask

    // n timebase ticks: each is one clock with tick high then one without.
    task automatic ticks(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(b, 1'b1);
            cyc(b, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BTN_EVENT_REPEAT_EN
        rep_en = 1'b1;
`else
        rep_en = 1'b0;
`endif
        clr();
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("rst_short", bus.short_press, 0);
        check("rst_long", bus.long_press, 0);
        check("rst_dbl", bus.double_click, 0);
        check("rst_rep", bus.repeat_press, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        // 1: short press
        clr();
        cyc(1'b1, 1'b0);
        check("t1_busy_press", bus.busy, 1);
        ticks(1'b1, 2);
        cyc(1'b0, 1'b0);
        ticks(1'b0, 2);
        check("t1_no_early_short", n_short, 0);
        cyc(1'b0, 1'b1);
        check("t1_short_pulse", bus.short_press, 1);
        check("t1_busy_fall", bus.busy, 0);
        cyc(1'b0, 1'b0);
        check("t1_short_one_clk", bus.short_press, 0);
        ticks(1'b0, 3);
        check("t1_short_count", n_short, 1);
        check("t1_other_events", n_long + n_dbl + n_rep, 0);

        // 2: double click
        clr();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        check("t2_dbl_pulse", bus.double_click, 1);
        cyc(1'b1, 1'b0);
        check("t2_dbl_one_clk", bus.double_click, 0);
        ticks(1'b1, 6);
        cyc(1'b0, 1'b0);
        check("t2_busy_idle", bus.busy, 0);
        ticks(1'b0, 4);
        check("t2_dbl_count", n_dbl, 1);
        check("t2_no_short", n_short, 0);
        check("t2_no_long_press2", n_long + n_rep, 0);

        // 3: long press then release
        clr();
        cyc(1'b1, 1'b0);
        ticks(1'b1, 3);
        check("t3_no_early_long", n_long, 0);
        cyc(1'b1, 1'b1);
        check("t3_long_pulse", bus.long_press, 1);
        cyc(1'b1, 1'b0);
        check("t3_long_one_clk", bus.long_press, 0);
        check("t3_busy_held", bus.busy, 1);
        cyc(1'b0, 1'b0);
        check("t3_busy_release", bus.busy, 0);
        ticks(1'b0, 4);
        check("t3_long_count", n_long, 1);
        check("t3_no_short", n_short, 0);

        // 4: auto-repeat while held
        clr();
        cyc(1'b1, 1'b0);
        ticks(1'b1, 3);
        cyc(1'b1, 1'b1);
        check("t4_long_tick4", bus.long_press, 1);
        cyc(1'b1, 1'b0);
        for (int k = 5; k <= 10; k++) begin
            cyc(1'b1, 1'b1);
            check($sformatf("t4_rep_tick%0d", k), bus.repeat_press, (rep_en && (k % 2 == 0)) ? 1 : 0);
            cyc(1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0);
        ticks(1'b0, 4);
        check("t4_rep_count", n_rep, rep_en ? 3 : 0);
        check("t4_long_count", n_long, 1);
        check("t4_no_short", n_short, 0);

        // 5: button held through reset
        clr();
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        ticks(1'b1, 6);
        check("t5_busy_held_rst", bus.busy, 0);
        check("t5_no_events", n_short + n_long + n_dbl + n_rep, 0);
        cyc(1'b0, 1'b0);
        check("t5_fall_ignored", bus.busy, 0);
        cyc(1'b1, 1'b0);
        check("t5_new_press", bus.busy, 1);
        cyc(1'b0, 1'b0);
        ticks(1'b0, 3);
        check("t5_short_count", n_short, 1);

        // 6a: rise coincident with tick in GAP at cnt==2
        clr();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        ticks(1'b0, 2);
        cyc(1'b1, 1'b1);
        check("t6_dbl_coincident", bus.double_click, 1);
        check("t6_short_coincident", bus.short_press, 0);
        cyc(1'b0, 1'b0);
        ticks(1'b0, 4);
        check("t6_no_short", n_short, 0);

        // 6b: reset in PRESS1 just as the long press would fire
        clr();
        cyc(1'b1, 1'b0);
        ticks(1'b1, 3);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        check("t6_rst_long", bus.long_press, 0);
        check("t6_rst_busy", bus.busy, 0);
        rst = 1'b0;
        ticks(1'b1, 4);
        check("t6_after_rst_long", n_long, 0);
        check("t6_after_rst_busy", bus.busy, 0);
        cyc(1'b0, 1'b0);
        ticks(1'b0, 4);
        check("t6_after_rst_short", n_short, 0);
        check("t6_no_multi", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
